// File: rtl/playback_engine.sv
// Trace-playback engine: replays stored stimulus vectors into a DUT, compares the
// DUT outputs against masked expected vectors after LAT cycles, and records failures.
module playback_engine #(
    parameter int IN_W   = 361,
    parameter int OUT_W  = 331,
    parameter int ADDR_W = 10,
    parameter int LAT    = 1,
    parameter int SKIP   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic              cfg_loop,
    input  logic [ADDR_W-1:0] cfg_last,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [IN_W-1:0]   load_stim,
    input  logic [OUT_W-1:0]  load_exp,
    input  logic [OUT_W-1:0]  load_mask,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic              first_fail_vld,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic [OUT_W-1:0]  first_fail_bits,
    output logic [ADDR_W-1:0] cur_idx
);
    localparam int DEPTH = 1 << ADDR_W;
    // The ordinal only has to answer "ordinal >= SKIP", so it saturates at SKIP.
    localparam int ORD_W = $clog2(SKIP + 2);
    localparam logic [ORD_W-1:0] SKIP_O = ORD_W'(SKIP);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    logic [IN_W-1:0]  stim_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem  [DEPTH];
    logic [OUT_W-1:0] mask_mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              loop_q, loop_d;
    logic [ORD_W-1:0]  ord_q, ord_d;
    logic [IN_W-1:0]   dut_in_q, dut_in_d;
    logic [LAT-1:0]    vld_q, vld_d;
    logic [LAT-1:0]    chk_q, chk_d;
    logic [ADDR_W-1:0] idx_q [LAT];
    logic [ADDR_W-1:0] idx_d [LAT];
    logic [OUT_W-1:0]  exp_q  [LAT];
    logic [OUT_W-1:0]  mask_q [LAT];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ffv_q, ffv_d;
    logic [ADDR_W-1:0] ffi_q, ffi_d;
    logic [OUT_W-1:0]  ffb_q, ffb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              start_ok;
    logic              issue;
    logic              wr_en;
    logic [OUT_W-1:0]  diff;
    logic              hit;

    assign start_ok = cfg_start && !cfg_abort && (state_q == IDLE || state_q == DONE);
    assign issue    = (state_q == RUN) && !cfg_abort;
    assign wr_en    = load_en && !(state_q == RUN || state_q == DRAIN);

    // A compare landing on the abort edge is dropped along with the pipeline.
    assign diff = (dut_out ^ exp_q[LAT-1]) & mask_q[LAT-1];
    assign hit  = vld_q[LAT-1] && chk_q[LAT-1] && (|diff) && !cfg_abort;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            stim_mem[load_addr] <= load_stim;
            exp_mem[load_addr]  <= load_exp;
            mask_mem[load_addr] <= load_mask;
        end
        if (issue) begin
            exp_q[0]  <= exp_mem[addr_q];
            mask_q[0] <= mask_mem[addr_q];
        end
        for (int i = 1; i < LAT; i++) begin
            exp_q[i]  <= exp_q[i-1];
            mask_q[i] <= mask_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        last_d   = last_q;
        loop_d   = loop_q;
        ord_d    = ord_q;
        dut_in_d = issue ? stim_mem[addr_q] : dut_in_q;

        vld_d[0] = issue;
        chk_d[0] = issue && (ord_q >= SKIP_O);
        idx_d[0] = addr_q;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            chk_d[i] = chk_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
        if (cfg_abort || start_ok) begin
            vld_d = '0;
        end

        if (cfg_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (cfg_start) begin
                        state_d = RUN;
                        addr_d  = '0;
                        last_d  = cfg_last;
                        loop_d  = cfg_loop;
                        ord_d   = '0;
                    end
                end
                RUN: begin
                    if (ord_q != SKIP_O) begin
                        ord_d = ord_q + ORD_W'(1);
                    end
                    if (addr_q == last_q) begin
                        if (loop_q) begin
                            addr_d = '0;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (vld_d == '0) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        cnt_d = cnt_q;
        ffv_d = ffv_q;
        ffi_d = ffi_q;
        ffb_d = ffb_q;
        if (start_ok) begin
            cnt_d = '0;
            ffv_d = 1'b0;
            ffi_d = '0;
            ffb_d = '0;
        end else if (hit) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!ffv_q) begin
                ffv_d = 1'b1;
                ffi_d = idx_q[LAT-1];
                ffb_d = diff;
            end
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            ord_q    <= '0;
            dut_in_q <= '0;
            vld_q    <= '0;
            chk_q    <= '0;
            for (int i = 0; i < LAT; i++) begin
                idx_q[i] <= '0;
            end
            cnt_q    <= '0;
            ffv_q    <= 1'b0;
            ffi_q    <= '0;
            ffb_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
            ord_q    <= ord_d;
            dut_in_q <= dut_in_d;
            vld_q    <= vld_d;
            chk_q    <= chk_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ffv_q    <= ffv_d;
            ffi_q    <= ffi_d;
            ffb_q    <= ffb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_in          = dut_in_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign mismatch_cnt    = cnt_q;
    assign first_fail_vld  = ffv_q;
    assign first_fail_idx  = ffi_q;
    assign first_fail_bits = ffb_q;
    assign cur_idx         = addr_q;

endmodule

// File: tb/tb_playback_engine.sv
// Directed and randomized checks of playback_engine against a vector-level reference model.
module tb_playback_engine;
    localparam int IN_W   = 361;
    localparam int OUT_W  = 331;
    localparam int ADDR_W = 5;
    localparam int LAT    = 1;
    localparam int SKIP   = 2;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0, cfg_abort = 1'b0, cfg_loop = 1'b0;
    logic [ADDR_W-1:0] cfg_last = '0;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [IN_W-1:0]   load_stim = '0;
    logic [OUT_W-1:0]  load_exp = '0, load_mask = '0;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              busy, done, pass, first_fail_vld;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [ADDR_W-1:0] first_fail_idx, cur_idx;
    logic [OUT_W-1:0]  first_fail_bits;

    playback_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .LAT(LAT),
                      .SKIP(SKIP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_loop(cfg_loop), .cfg_last(cfg_last), .load_en(load_en),
        .load_addr(load_addr), .load_stim(load_stim), .load_exp(load_exp),
        .load_mask(load_mask), .dut_in(dut_in), .dut_out(dut_out), .busy(busy),
        .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
        .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
        .first_fail_bits(first_fail_bits), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    // Same-cycle device under test, so outputs are ready one cycle after issue (LAT = 1).
    assign dut_out = ~dut_in[OUT_W-1:0];

    logic [IN_W-1:0]  m_stim [DEPTH];
    logic [OUT_W-1:0] m_exp  [DEPTH];
    logic [OUT_W-1:0] m_mask [DEPTH];
    int               e_cnt, e_ffi;
    logic             e_ffv;
    logic [OUT_W-1:0] e_ffb;
    int               n_chk = 0;
    int               n_fail = 0;

    function automatic logic [OUT_W-1:0] f(input logic [IN_W-1:0] s);
        return ~s[OUT_W-1:0];
    endfunction

    function automatic logic [511:0] rv();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the vector sequence in issue order and apply the compare rules.
    task automatic predict(input int last, input bit loop, input int ncmp);
        e_cnt = 0; e_ffv = 1'b0; e_ffi = 0; e_ffb = '0;
        for (int j = 0; j < ncmp; j++) begin
            int a;
            logic [OUT_W-1:0] d;
            a = loop ? (j % (last + 1)) : j;
            d = (f(m_stim[a]) ^ m_exp[a]) & m_mask[a];
            if (j >= SKIP && d != '0) begin
                if (e_cnt < CMAX) e_cnt++;
                if (!e_ffv) begin
                    e_ffv = 1'b1; e_ffi = a; e_ffb = d;
                end
            end
        end
    endtask

    task automatic load_one(input int a, input logic [IN_W-1:0] s,
                            input logic [OUT_W-1:0] e, input logic [OUT_W-1:0] m);
        load_addr = ADDR_W'(a); load_stim = s; load_exp = e; load_mask = m; load_en = 1'b1;
        m_stim[a] = s; m_exp[a] = e; m_mask[a] = m;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Loads every address; each expected vector is corrupted in one bit with probability pct%.
    task automatic load_all(input int pct, input bit rand_mask);
        for (int a = 0; a < DEPTH; a++) begin
            logic [IN_W-1:0]  s;
            logic [OUT_W-1:0] e, m;
            s = rv();
            e = f(s);
            if ($urandom_range(99) < pct) e[$urandom_range(OUT_W-1)] ^= 1'b1;
            m = rand_mask ? OUT_W'(rv()) : '1;
            load_one(a, s, e, m);
        end
    endtask

    task automatic start_run(input int last, input bit loop);
        cfg_last = ADDR_W'(last); cfg_loop = loop; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        chk({tag, " cnt"}, mismatch_cnt, e_cnt);
        chk({tag, " ffv"}, first_fail_vld, e_ffv);
        chk({tag, " ffi"}, first_fail_idx, e_ffi);
        chk({tag, " ffb"}, first_fail_bits, e_ffb);
    endtask

    task automatic run_check(input string tag, input int last);
        int cyc;
        start_run(last, 1'b0);
        chk({tag, " busy"}, busy, 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        predict(last, 1'b0, last + 1);
        chk({tag, " latency"}, cyc, last + 1 + LAT);
        chk({tag, " pass"}, pass, (e_cnt == 0));
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " hold"}, dut_in, m_stim[last]);
        check_result(tag);
        $display("run %s last=%0d cycles=%0d cnt=%0d pass=%0d", tag, last, cyc, mismatch_cnt, pass);
    endtask

    task automatic loop_abort(input string tag, input int last, input int n);
        start_run(last, 1'b1);
        repeat (n) @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        predict(last, 1'b1, n - LAT);
        chk({tag, " done"}, done, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " pass"}, pass, 0);
        chk({tag, " hold"}, dut_in, m_stim[(n - 1) % (last + 1)]);
        check_result(tag);
        $display("loop %s last=%0d issues=%0d cnt=%0d", tag, last, n, mismatch_cnt);
    endtask

    initial begin
        logic [OUT_W-1:0] bit5;
        bit5 = '0;
        bit5[5] = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst dut_in", dut_in, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst cnt", mismatch_cnt, 0);
        chk("rst ffv", first_fail_vld, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 8; a++) begin
            logic [IN_W-1:0] s;
            s = rv();
            load_one(a, s, f(s), '1);
        end
        run_check("clean8", 7);
        chk("clean8 pass_lit", pass, 1);

        load_one(3, m_stim[3], m_exp[3] ^ bit5, '1);
        run_check("bad3", 7);
        chk("bad3 cnt_lit", mismatch_cnt, 1);
        chk("bad3 ffi_lit", first_fail_idx, 3);
        chk("bad3 ffb_lit", first_fail_bits, bit5);

        load_one(3, m_stim[3], m_exp[3], ~bit5);
        run_check("masked3", 7);
        chk("masked3 pass_lit", pass, 1);

        load_one(3, m_stim[3], f(m_stim[3]), '1);
        load_one(0, m_stim[0], ~f(m_stim[0]), '1);
        load_one(1, m_stim[1], f(m_stim[1]) ^ bit5, '1);
        run_check("skip01", 7);
        chk("skip01 pass_lit", pass, 1);

        for (int a = 0; a < 4; a++) load_one(a, m_stim[a], f(m_stim[a]) ^ ((a == 2) ? bit5 : '0), '1);
        loop_abort("loop4", 3, 20);
        chk("loop4 cnt_lit", mismatch_cnt, 5);
        chk("loop4 ffi_lit", first_fail_idx, 2);

        cfg_start = 1'b1; cfg_abort = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; cfg_abort = 1'b0;
        chk("abort_start busy", busy, 0);
        chk("abort_start cnt_held", mismatch_cnt, 5);

        load_all(100, 1'b0);
        run_check("sat32", 31);
        chk("sat32 cnt_lit", mismatch_cnt, CMAX);

        load_all(20, 1'b0);
        start_run(31, 1'b0);
        repeat (5) @(negedge clk);
        load_addr = '0; load_stim = ~m_stim[0]; load_exp = '0; load_mask = '1;
        load_en = 1'b1; cfg_start = 1'b1;
        @(negedge clk);
        load_en = 1'b0; cfg_start = 1'b0;
        repeat (40) @(negedge clk);
        predict(31, 1'b0, 32);
        chk("busyload done", done, 1);
        check_result("busyload");
        run_check("single", 0);

        for (int it = 0; it < 4; it++) begin
            load_all(30, 1'b1);
            run_check($sformatf("rand%0d", it), $urandom_range(DEPTH - 1));
        end
        for (int it = 0; it < 2; it++) begin
            loop_abort($sformatf("rloop%0d", it), $urandom_range(7), $urandom_range(40, 10));
        end

        start_run(31, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst dut_in", dut_in, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst done", done, 0);
        chk("mid_rst pass", pass, 0);
        chk("mid_rst cnt", mismatch_cnt, 0);
        chk("mid_rst ffv", first_fail_vld, 0);
        chk("mid_rst ffi", first_fail_idx, 0);
        chk("mid_rst ffb", first_fail_bits, 0);
        chk("mid_rst cur_idx", cur_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst busy", busy, 0);
        chk("post_rst done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
